// File: rtl/sayeh_fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sayeh_fetch_sequencer_pkg
// Purpose  : Shared definitions for the SAYEH fetch sequencer: FSM state
//            encoding, instruction class codes, PC-source select bundle and
//            the class-to-select decode used in both EXEC and SHADOW.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sayeh_fetch_sequencer_pkg;

   localparam int c_cls_w = 3;

   // Sequencer states, explicit 3-bit encoding
   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_EXEC   = 3'd3,
      ST_SHADOW = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   // Instruction class codes delivered by the decoder
   localparam logic [c_cls_w-1:0] c_cls_seq  = 3'b000;
   localparam logic [c_cls_w-1:0] c_cls_brz  = 3'b001;
   localparam logic [c_cls_w-1:0] c_cls_brc  = 3'b010;
   localparam logic [c_cls_w-1:0] c_cls_jpr  = 3'b011;
   localparam logic [c_cls_w-1:0] c_cls_jpa  = 3'b100;
   localparam logic [c_cls_w-1:0] c_cls_halt = 3'b101;
   localparam logic [c_cls_w-1:0] c_cls_nop  = 3'b110;
   localparam logic [c_cls_w-1:0] c_cls_rsvd = 3'b111;

   // One-hot PC-source select bundle; all zero means "hold PC"
   typedef struct packed {
      logic resetpc;
      logic pcplusi;
      logic pcplus1;
      logic iplus0;
      logic rplus0;
   } pc_sel_t;

   localparam pc_sel_t c_sel_none = '0;

   // Select for one instruction half. HALT yields no select at all.
   function automatic pc_sel_t class_select(input logic [c_cls_w-1:0] cls,
                                            input logic               zflag,
                                            input logic               cflag);
      pc_sel_t sel;
      sel = c_sel_none;
      case (cls)
         c_cls_brz:  if (zflag) sel.pcplusi = 1'b1; else sel.pcplus1 = 1'b1;
         c_cls_brc:  if (cflag) sel.pcplusi = 1'b1; else sel.pcplus1 = 1'b1;
         c_cls_jpr:  sel.rplus0 = 1'b1;
         c_cls_jpa:  sel.iplus0 = 1'b1;
         c_cls_halt: sel = c_sel_none;
         default:    sel.pcplus1 = 1'b1;   // SEQ, NOP, reserved
      endcase
      return sel;
   endfunction

   // Classes that never redirect the PC; only these let a short
   // instruction fall through to its low byte.
   function automatic logic is_inline_class(input logic [c_cls_w-1:0] cls);
      return (cls == c_cls_seq) || (cls == c_cls_nop) || (cls == c_cls_rsvd);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sayeh_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sayeh_fetch_sequencer_if
// Purpose  : Bundles the sequencer's memory handshake, decoder inputs and
//            address-path control outputs.
// Ports    : master - sequencer side (drives ReadMem/IRload/selects/status)
//            slave  - memory/decoder/address-path side
// Revision : 1.0 - initial release
// ============================================================================
interface sayeh_fetch_sequencer_if;
   import sayeh_fetch_sequencer_pkg::*;

   // Inputs to the sequencer
   logic               MemDataReady;
   logic [c_cls_w-1:0] InstClass;
   logic               ShortInst;
   logic               Zflag;
   logic               Cflag;

   // Outputs from the sequencer
   logic ReadMem;
   logic IRload;
   logic EnablePC;
   logic ResetPC;
   logic PCplusI;
   logic PCplus1;
   logic Iplus0;
   logic Rplus0;
   logic Shadow;
   logic Halted;
   logic MemFault;
   logic IllegalOp;

   modport master (
      input  MemDataReady, InstClass, ShortInst, Zflag, Cflag,
      output ReadMem, IRload, EnablePC, ResetPC, PCplusI, PCplus1,
             Iplus0, Rplus0, Shadow, Halted, MemFault, IllegalOp
   );

   modport slave (
      output MemDataReady, InstClass, ShortInst, Zflag, Cflag,
      input  ReadMem, IRload, EnablePC, ResetPC, PCplusI, PCplus1,
             Iplus0, Rplus0, Shadow, Halted, MemFault, IllegalOp
   );

endinterface
`default_nettype wire

// File: rtl/sayeh_fetch_sequencer_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : sayeh_fetch_sequencer_mem_wait_timer
// Purpose  : Counts cycles spent waiting for an instruction word.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            i_clr        - clear counter (wins over i_en)
//            i_en         - count this cycle
//            o_expired    - this enabled cycle is the MEM_WAIT_MAX-th one
// Revision : 1.0 - initial release
// ============================================================================
module sayeh_fetch_sequencer_mem_wait_timer #(
   parameter int MEM_WAIT_MAX = 15,
   parameter int WAIT_W       = 4
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_clr,
   input  wire logic i_en,
   output logic      o_expired
);

   // Count value held during the last permitted wait cycle
   localparam logic [WAIT_W-1:0] c_last = WAIT_W'(MEM_WAIT_MAX - 1);

   logic [WAIT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + 1'b1;
      end
   end

   // Flags the cycle whose increment would make the count reach MEM_WAIT_MAX
   assign o_expired = i_en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/sayeh_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sayeh_fetch_sequencer
// Purpose  : SAYEH fetch/load/execute control. Runs the memory read
//            handshake, resolves branches, sequences the low byte of short
//            instructions, and handles HALT and memory-wait timeout.
// Ports    : clk           - system clock
//            ExternalReset - synchronous active-high reset
//            bus           - sayeh_fetch_sequencer_if.master (handshake,
//                            decoder inputs, PC-source selects, status)
// Revision : 1.0 - initial release
// ============================================================================
module sayeh_fetch_sequencer
   import sayeh_fetch_sequencer_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15,
   parameter int WAIT_W       = 4
) (
   input  wire logic                 clk,
   input  wire logic                 ExternalReset,
   sayeh_fetch_sequencer_if.master   bus
);

   state_t  r_state;
   state_t  w_next;
   logic    r_mem_fault;

   logic    w_tmr_clr;
   logic    w_tmr_en;
   logic    w_expired;
   logic    w_timeout;

   pc_sel_t w_cls_sel;
   pc_sel_t w_sel;
   logic    w_readmem;
   logic    w_irload;
   logic    w_enablepc;
   logic    w_shadow;
   logic    w_halted;
   logic    w_illegal;

   // ------------------------------------------------------------------
   // Memory wait timer: runs only while fetching and not yet served
   // ------------------------------------------------------------------
   assign w_tmr_en  = (r_state == ST_FETCH);
   assign w_tmr_clr = (r_state != ST_FETCH) || bus.MemDataReady;

   sayeh_fetch_sequencer_mem_wait_timer #(
      .MEM_WAIT_MAX (MEM_WAIT_MAX),
      .WAIT_W       (WAIT_W)
   ) u_wait_timer (
      .clk       (clk),
      .rst       (ExternalReset),
      .i_clr     (w_tmr_clr),
      .i_en      (w_tmr_en),
      .o_expired (w_expired)
   );

   // A ready on the expiry cycle is still accepted
   assign w_timeout = (r_state == ST_FETCH) && !bus.MemDataReady && w_expired;

   assign w_cls_sel = class_select(bus.InstClass, bus.Zflag, bus.Cflag);

   // ------------------------------------------------------------------
   // State and sticky fault register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (ExternalReset) begin
         r_state     <= ST_RST;
         r_mem_fault <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_RST) begin
            r_mem_fault <= 1'b0;
         end else if (w_timeout) begin
            r_mem_fault <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Next state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      w_next     = r_state;
      w_sel      = c_sel_none;
      w_readmem  = 1'b0;
      w_irload   = 1'b0;
      w_enablepc = 1'b0;
      w_shadow   = 1'b0;
      w_halted   = 1'b0;
      w_illegal  = 1'b0;

      case (r_state)
         ST_RST: begin
            w_sel.resetpc = 1'b1;
            w_enablepc    = 1'b1;
            w_next        = ST_FETCH;
         end

         ST_FETCH: begin
            w_readmem = 1'b1;
            if (bus.MemDataReady) begin
               w_next = ST_LOAD;
            end else if (w_timeout) begin
               w_next = ST_HALT;
            end
         end

         ST_LOAD: begin
            w_irload = 1'b1;
            w_next   = ST_EXEC;
         end

         ST_EXEC: begin
            w_illegal = (bus.InstClass == c_cls_rsvd);
            if (bus.InstClass == c_cls_halt) begin
               w_next = ST_HALT;
            end else if (bus.ShortInst && is_inline_class(bus.InstClass)) begin
               // PC is held so the low byte of the same word runs next
               w_next = ST_SHADOW;
            end else begin
               w_sel      = w_cls_sel;
               w_enablepc = 1'b1;
               w_next     = ST_FETCH;
            end
         end

         ST_SHADOW: begin
            w_shadow  = 1'b1;
            w_illegal = (bus.InstClass == c_cls_rsvd);
            if (bus.InstClass == c_cls_halt) begin
               w_next = ST_HALT;
            end else begin
               w_sel      = w_cls_sel;
               w_enablepc = 1'b1;
               w_next     = ST_FETCH;
            end
         end

         ST_HALT: begin
            w_halted = 1'b1;
            w_next   = ST_HALT;
         end

         default: begin
            w_next = ST_RST;
         end
      endcase
   end

   assign bus.ReadMem   = w_readmem;
   assign bus.IRload    = w_irload;
   assign bus.EnablePC  = w_enablepc;
   assign bus.ResetPC   = w_sel.resetpc;
   assign bus.PCplusI   = w_sel.pcplusi;
   assign bus.PCplus1   = w_sel.pcplus1;
   assign bus.Iplus0    = w_sel.iplus0;
   assign bus.Rplus0    = w_sel.rplus0;
   assign bus.Shadow    = w_shadow;
   assign bus.Halted    = w_halted;
   assign bus.MemFault  = r_mem_fault;
   assign bus.IllegalOp = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_sayeh_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sayeh_fetch_sequencer
// Purpose  : Directed self-checking bench for sayeh_fetch_sequencer.
//            Inputs change just after the falling edge; outputs are checked
//            1 time unit later, well away from the rising edge.
//            Observed outputs are packed as
//            {ReadMem,IRload,EnablePC,ResetPC,PCplusI,PCplus1,Iplus0,Rplus0,
//             Shadow,Halted,MemFault,IllegalOp}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sayeh_fetch_sequencer;

   logic clk;
   logic ext_rst;
   int   total;
   int   bad;

   sayeh_fetch_sequencer_if bus ();

   sayeh_fetch_sequencer #(
      .MEM_WAIT_MAX (15),
      .WAIT_W       (4)
   ) dut (
      .clk           (clk),
      .ExternalReset (ext_rst),
      .bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output vectors
   localparam logic [11:0] O_RST     = 12'b0011_0000_0000;
   localparam logic [11:0] O_FETCH   = 12'b1000_0000_0000;
   localparam logic [11:0] O_LOAD    = 12'b0100_0000_0000;
   localparam logic [11:0] O_NONE    = 12'b0000_0000_0000;
   localparam logic [11:0] O_P1      = 12'b0010_0100_0000;
   localparam logic [11:0] O_PI      = 12'b0010_1000_0000;
   localparam logic [11:0] O_I0      = 12'b0010_0010_0000;
   localparam logic [11:0] O_R0      = 12'b0010_0001_0000;
   localparam logic [11:0] O_SH_I0   = 12'b0010_0010_1000;
   localparam logic [11:0] O_SH_NONE = 12'b0000_0000_1000;
   localparam logic [11:0] O_HALT    = 12'b0000_0000_0100;
   localparam logic [11:0] O_HALT_F  = 12'b0000_0000_0110;
   localparam logic [11:0] O_ILL     = 12'b0010_0100_0001;

   function automatic logic [11:0] outs();
      return {bus.ReadMem, bus.IRload, bus.EnablePC, bus.ResetPC, bus.PCplusI,
              bus.PCplus1, bus.Iplus0, bus.Rplus0, bus.Shadow, bus.Halted,
              bus.MemFault, bus.IllegalOp};
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // From a FETCH cycle: wait 'waits' cycles, deliver the word, pass LOAD.
   // Returns at the start of the EXEC cycle.
   task automatic goto_exec(input int waits);
      for (int i = 0; i < waits; i++) begin
         bus.MemDataReady = 1'b0;
         step();
      end
      bus.MemDataReady = 1'b1;
      step();
      bus.MemDataReady = 1'b0;
      step();
   endtask

   // Reset for two cycles, release, and return at the first FETCH cycle
   task automatic do_reset();
      bus.MemDataReady = 1'b0;
      bus.ShortInst    = 1'b0;
      ext_rst          = 1'b1;
      step();
      step();
      ext_rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      ext_rst = 1'b1;
      bus.MemDataReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         total++;
         if (outs() !== O_RST) begin
            bad++;
            $display("FAIL reset_cycle%0d: got %b want %b", i, outs(), O_RST);
         end
      end
      ext_rst = 1'b0;
      step();
      #1;
      total++;
      if (outs() !== O_FETCH) begin
         bad++;
         $display("FAIL reset_release_fetch: got %b want %b", outs(), O_FETCH);
      end
   endtask

   task automatic test_seq();
      for (int i = 0; i < 3; i++) begin
         bus.MemDataReady = (i == 2);
         #1;
         total++;
         if (outs() !== O_FETCH) begin
            bad++;
            $display("FAIL seq_fetch%0d: got %b want %b", i, outs(), O_FETCH);
         end
         step();
      end
      bus.MemDataReady = 1'b0;
      #1;
      total++;
      if (outs() !== O_LOAD) begin
         bad++;
         $display("FAIL seq_load: got %b want %b", outs(), O_LOAD);
      end
      step();
      bus.InstClass = 3'b000;
      bus.ShortInst = 1'b0;
      #1;
      total++;
      if (outs() !== O_P1) begin
         bad++;
         $display("FAIL seq_exec: got %b want %b", outs(), O_P1);
      end
      step();
      #1;
      total++;
      if (outs() !== O_FETCH) begin
         bad++;
         $display("FAIL seq_back_fetch: got %b want %b", outs(), O_FETCH);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 2; k++) begin
         bus.MemDataReady = 1'b1;
         #1;
         total++;
         if (outs() !== O_FETCH) begin
            bad++;
            $display("FAIL b2b_fetch%0d: got %b want %b", k, outs(), O_FETCH);
         end
         step();
         bus.MemDataReady = 1'b0;
         #1;
         total++;
         if (outs() !== O_LOAD) begin
            bad++;
            $display("FAIL b2b_load%0d: got %b want %b", k, outs(), O_LOAD);
         end
         step();
         bus.InstClass = 3'b110;
         #1;
         total++;
         if (outs() !== O_P1) begin
            bad++;
            $display("FAIL b2b_exec_nop%0d: got %b want %b", k, outs(), O_P1);
         end
         step();
      end
   endtask

   task automatic test_branches();
      logic [2:0]  cls_t [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b011, 3'b100};
      logic        z_t   [6] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1};
      logic        c_t   [6] = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0};
      logic [11:0] exp_t [6] = '{O_PI,   O_P1,   O_PI,   O_P1,   O_R0,   O_I0};
      for (int i = 0; i < 6; i++) begin
         goto_exec(i % 2);
         bus.InstClass = cls_t[i];
         bus.Zflag     = z_t[i];
         bus.Cflag     = c_t[i];
         bus.ShortInst = 1'b0;
         #1;
         total++;
         if (outs() !== exp_t[i]) begin
            bad++;
            $display("FAIL branch%0d cls=%b z=%b c=%b: got %b want %b",
                     i, cls_t[i], z_t[i], c_t[i], outs(), exp_t[i]);
         end
         step();
         #1;
         total++;
         if (outs() !== O_FETCH) begin
            bad++;
            $display("FAIL branch%0d_return: got %b want %b", i, outs(), O_FETCH);
         end
      end
      bus.Zflag = 1'b0;
      bus.Cflag = 1'b0;
   endtask

   task automatic test_shadow();
      goto_exec(0);
      bus.InstClass = 3'b000;
      bus.ShortInst = 1'b1;
      #1;
      total++;
      if (outs() !== O_NONE) begin
         bad++;
         $display("FAIL shadow_exec_hold: got %b want %b", outs(), O_NONE);
      end
      step();
      bus.InstClass = 3'b100;
      #1;
      total++;
      if (outs() !== O_SH_I0) begin
         bad++;
         $display("FAIL shadow_low_jpa: got %b want %b", outs(), O_SH_I0);
      end
      step();
      bus.ShortInst = 1'b0;
      #1;
      total++;
      if (outs() !== O_FETCH) begin
         bad++;
         $display("FAIL shadow_return: got %b want %b", outs(), O_FETCH);
      end
      // Taken jump in the high byte skips the low byte
      goto_exec(0);
      bus.InstClass = 3'b100;
      bus.ShortInst = 1'b1;
      #1;
      total++;
      if (outs() !== O_I0) begin
         bad++;
         $display("FAIL short_jump_exec: got %b want %b", outs(), O_I0);
      end
      step();
      bus.ShortInst = 1'b0;
      #1;
      total++;
      if (outs() !== O_FETCH) begin
         bad++;
         $display("FAIL short_jump_skips_low: got %b want %b", outs(), O_FETCH);
      end
   endtask

   task automatic test_illegal();
      goto_exec(1);
      bus.InstClass = 3'b111;
      bus.ShortInst = 1'b0;
      #1;
      total++;
      if (outs() !== O_ILL) begin
         bad++;
         $display("FAIL illegal_exec: got %b want %b", outs(), O_ILL);
      end
      step();
      #1;
      total++;
      if (outs() !== O_FETCH) begin
         bad++;
         $display("FAIL illegal_pulse_end: got %b want %b", outs(), O_FETCH);
      end
   endtask

   task automatic test_halt_class();
      goto_exec(0);
      bus.InstClass = 3'b101;
      #1;
      total++;
      if (outs() !== O_NONE) begin
         bad++;
         $display("FAIL halt_exec: got %b want %b", outs(), O_NONE);
      end
      step();
      bus.MemDataReady = 1'b1;
      #1;
      total++;
      if (outs() !== O_HALT) begin
         bad++;
         $display("FAIL halt_state: got %b want %b", outs(), O_HALT);
      end
      step();
      #1;
      total++;
      if (outs() !== O_HALT) begin
         bad++;
         $display("FAIL halt_hold: got %b want %b", outs(), O_HALT);
      end
      do_reset();
      // HALT class in the low byte of a short instruction
      goto_exec(0);
      bus.InstClass = 3'b000;
      bus.ShortInst = 1'b1;
      step();
      bus.InstClass = 3'b101;
      #1;
      total++;
      if (outs() !== O_SH_NONE) begin
         bad++;
         $display("FAIL shadow_halt: got %b want %b", outs(), O_SH_NONE);
      end
      step();
      #1;
      total++;
      if (outs() !== O_HALT) begin
         bad++;
         $display("FAIL shadow_halt_state: got %b want %b", outs(), O_HALT);
      end
      do_reset();
   endtask

   task automatic test_timeout_ready_wins();
      for (int i = 0; i < 15; i++) begin
         bus.MemDataReady = (i == 14);
         step();
      end
      bus.MemDataReady = 1'b0;
      #1;
      total++;
      if (outs() !== O_LOAD) begin
         bad++;
         $display("FAIL timeout_ready_wins: got %b want %b", outs(), O_LOAD);
      end
      step();
      bus.InstClass = 3'b000;
      bus.ShortInst = 1'b0;
      step();
   endtask

   task automatic test_timeout();
      bus.MemDataReady = 1'b0;
      for (int i = 0; i < 15; i++) begin
         #1;
         total++;
         if (outs() !== O_FETCH) begin
            bad++;
            $display("FAIL timeout_wait%0d: got %b want %b", i, outs(), O_FETCH);
         end
         step();
      end
      #1;
      total++;
      if (outs() !== O_HALT_F) begin
         bad++;
         $display("FAIL timeout_halt: got %b want %b", outs(), O_HALT_F);
      end
      for (int i = 0; i < 3; i++) begin
         bus.MemDataReady = 1'b1;
         step();
         #1;
         total++;
         if (outs() !== O_HALT_F) begin
            bad++;
            $display("FAIL timeout_stays%0d: got %b want %b", i, outs(), O_HALT_F);
         end
      end
      bus.MemDataReady = 1'b0;
      ext_rst = 1'b1;
      step();
      #1;
      total++;
      if (outs() !== O_RST) begin
         bad++;
         $display("FAIL timeout_reset_clears: got %b want %b", outs(), O_RST);
      end
      ext_rst = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_fetch();
      bus.MemDataReady = 1'b0;
      step();
      ext_rst = 1'b1;
      #1;
      total++;
      if (outs() !== O_FETCH) begin
         bad++;
         $display("FAIL mid_fetch_before: got %b want %b", outs(), O_FETCH);
      end
      step();
      bus.MemDataReady = 1'b1;
      #1;
      total++;
      if (outs() !== O_RST) begin
         bad++;
         $display("FAIL mid_fetch_rst: got %b want %b", outs(), O_RST);
      end
      step();
      ext_rst = 1'b0;
      #1;
      total++;
      if (outs() !== O_RST) begin
         bad++;
         $display("FAIL mid_fetch_rst_hold: got %b want %b", outs(), O_RST);
      end
      step();
      bus.MemDataReady = 1'b0;
      #1;
      total++;
      if (outs() !== O_FETCH) begin
         bad++;
         $display("FAIL mid_fetch_refetch: got %b want %b", outs(), O_FETCH);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      ext_rst          = 1'b1;
      bus.MemDataReady = 1'b0;
      bus.InstClass    = 3'b000;
      bus.ShortInst    = 1'b0;
      bus.Zflag        = 1'b0;
      bus.Cflag        = 1'b0;

      test_reset();
      test_seq();
      test_back_to_back();
      test_branches();
      test_shadow();
      test_illegal();
      test_halt_class();
      test_timeout_ready_wins();
      test_timeout();
      test_reset_mid_fetch();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
